// File: rtl/fifo_level.sv
// Synchronous FIFO with explicit fill level, almost-full/empty thresholds, flush and sticky errors.
// Optional macro FIFO_LEVEL_ERR_EN enables the overflow/underflow sticky flags and clr_err_i.
module fifo_level #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CW-1:0]    level_o,
  input  logic [CW-1:0]    afull_thresh_i,
  input  logic [CW-1:0]    aempty_thresh_i,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic             overflow_o,
  output logic             underflow_o,
  input  logic             clr_err_i
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_level;
  logic [CW-1:0]    w_level_nxt;
  logic             w_tunnel;
  logic             w_wr_acc;
  logic             w_rd_acc;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      ptr_inc = {PW{1'b0}};
    end else begin
      ptr_inc = p + PW'(1);
    end
  endfunction

  assign empty_o        = (r_level == {CW{1'b0}});
  assign full_o         = (r_level == CW'(DEPTH));
  assign level_o        = r_level;
  assign almost_full_o  = (r_level >= afull_thresh_i);
  assign almost_empty_o = (r_level <= aempty_thresh_i);

  assign w_tunnel  = wr_en_i & rd_en_i & empty_o;
  assign w_wr_acc  = wr_en_i & (~full_o | rd_en_i) & ~w_tunnel;
  assign w_rd_acc  = rd_en_i & ~empty_o;
  assign rd_data_o = w_tunnel ? wr_data_i : r_mem[r_rd_ptr];

  // Level follows accepted pushes and pops; simultaneous push+pop leaves it unchanged.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_level_nxt = r_level + CW'(1);
      2'b01:   w_level_nxt = r_level - CW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Pointer and level registers; flush clears them but leaves memory contents alone.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_level  <= {CW{1'b0}};
    end else if (flush_i) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_level  <= {CW{1'b0}};
    end else begin
      if (w_wr_acc) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_rd_acc) r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_level <= w_level_nxt;
    end
  end

  // Storage array, written only by accepted pushes.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i && w_wr_acc) begin
      r_mem[r_wr_ptr] <= wr_data_i;
    end
  end

`ifdef FIFO_LEVEL_ERR_EN
  logic r_overflow;
  logic r_underflow;
  logic w_ovf_evt;
  logic w_udf_evt;

  assign w_ovf_evt   = wr_en_i & full_o & ~rd_en_i & ~flush_i;
  assign w_udf_evt   = rd_en_i & empty_o & ~wr_en_i & ~flush_i;
  assign overflow_o  = r_overflow;
  assign underflow_o = r_underflow;

  // Sticky error flags; a new event outranks a same-cycle clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_evt)      r_overflow <= 1'b1;
      else if (clr_err_i) r_overflow <= 1'b0;
      if (w_udf_evt)      r_underflow <= 1'b1;
      else if (clr_err_i) r_underflow <= 1'b0;
    end
  end
`else
  logic w_unused_clr;

  assign w_unused_clr = clr_err_i;
  assign overflow_o   = 1'b0;
  assign underflow_o  = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_level.sv
// Directed self-checking bench for fifo_level: DEPTH 5 main instance plus a DEPTH 1 instance.
module tb_fifo_level;

`ifdef FIFO_LEVEL_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] rd_data;
  logic       empty, full, afull, aempty, ovf, udf;
  logic [2:0] level;
  logic [2:0] afull_th = 3'd4;
  logic [2:0] aempty_th = 3'd1;

  logic       d1_wr_en = 1'b0, d1_rd_en = 1'b0;
  logic [7:0] d1_wr_data = 8'h00;
  logic [7:0] d1_rd_data;
  logic       d1_empty, d1_full, d1_afull, d1_aempty, d1_ovf, d1_udf;
  logic [0:0] d1_level;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fifo_level #(.WIDTH(8), .DEPTH(5)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_data_o(rd_data), .empty_o(empty), .full_o(full), .level_o(level),
    .afull_thresh_i(afull_th), .aempty_thresh_i(aempty_th), .almost_full_o(afull),
    .almost_empty_o(aempty), .overflow_o(ovf), .underflow_o(udf), .clr_err_i(clr_err)
  );

  fifo_level #(.WIDTH(8), .DEPTH(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(1'b0), .wr_en_i(d1_wr_en), .wr_data_i(d1_wr_data),
    .rd_en_i(d1_rd_en), .rd_data_o(d1_rd_data), .empty_o(d1_empty), .full_o(d1_full),
    .level_o(d1_level), .afull_thresh_i(1'b1), .aempty_thresh_i(1'b0),
    .almost_full_o(d1_afull), .almost_empty_o(d1_aempty), .overflow_o(d1_ovf),
    .underflow_o(d1_udf), .clr_err_i(1'b0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n_checks++; if (level !== 3'd0)  $display("FAIL reset_level: got %0d want 0", level); else n_pass++;
    n_checks++; if (empty !== 1'b1)  $display("FAIL reset_empty: got %b want 1", empty); else n_pass++;
    n_checks++; if (full !== 1'b0)   $display("FAIL reset_full: got %b want 0", full); else n_pass++;
    n_checks++; if (aempty !== 1'b1) $display("FAIL reset_aempty: got %b want 1", aempty); else n_pass++;
    n_checks++; if (afull !== 1'b0)  $display("FAIL reset_afull: got %b want 0", afull); else n_pass++;
    n_checks++; if (ovf !== 1'b0 || udf !== 1'b0) $display("FAIL reset_flags: got %b%b want 00", ovf, udf); else n_pass++;
  endtask

  task automatic test_fill_drain();
    for (int r = 0; r < 3; r++) begin
      for (int i = 1; i <= 5; i++) push(8'(i));
      n_checks++; if (full !== 1'b1)  $display("FAIL fill_full r%0d: got %b want 1", r, full); else n_pass++;
      n_checks++; if (level !== 3'd5) $display("FAIL fill_level r%0d: got %0d want 5", r, level); else n_pass++;
      for (int i = 1; i <= 5; i++) begin
        rd_en = 1'b1;
        #1;
        n_checks++; if (rd_data !== 8'(i)) $display("FAIL drain_data r%0d i%0d: got %h want %h", r, i, rd_data, 8'(i)); else n_pass++;
        tick();
        rd_en = 1'b0;
      end
      n_checks++; if (empty !== 1'b1) $display("FAIL drain_empty r%0d: got %b want 1", r, empty); else n_pass++;
    end
  endtask

  task automatic test_tunnel();
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hA5;
    #1;
    n_checks++; if (rd_data !== 8'hA5) $display("FAIL tunnel_data: got %h want a5", rd_data); else n_pass++;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    n_checks++; if (level !== 3'd0) $display("FAIL tunnel_level: got %0d want 0", level); else n_pass++;
    n_checks++; if (udf !== 1'b0)   $display("FAIL tunnel_udf: got %b want 0", udf); else n_pass++;
  endtask

  task automatic test_thresholds();
    logic [7:0] exp_q [5];
    for (int l = 0; l <= 5; l++) begin
      n_checks++; if (aempty !== (l <= 1)) $display("FAIL thr_aempty l%0d: got %b want %b", l, aempty, (l <= 1)); else n_pass++;
      n_checks++; if (afull !== (l >= 4))  $display("FAIL thr_afull l%0d: got %b want %b", l, afull, (l >= 4)); else n_pass++;
      if (l < 5) push(8'h10 + 8'(l));
    end
    // Full now holds 10..14: overflow, then push+pop at full.
    push(8'h77);
    n_checks++; if (ovf !== ERR)     $display("FAIL ovf_set: got %b want %b", ovf, ERR); else n_pass++;
    n_checks++; if (level !== 3'd5)  $display("FAIL ovf_level: got %0d want 5", level); else n_pass++;
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h88;
    #1;
    n_checks++; if (rd_data !== 8'h10) $display("FAIL fullrw_head: got %h want 10", rd_data); else n_pass++;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    n_checks++; if (level !== 3'd5) $display("FAIL fullrw_level: got %0d want 5", level); else n_pass++;
    exp_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h88};
    for (int i = 0; i < 5; i++) begin
      rd_en = 1'b1;
      #1;
      n_checks++; if (rd_data !== exp_q[i]) $display("FAIL fullrw_data i%0d: got %h want %h", i, rd_data, exp_q[i]); else n_pass++;
      tick();
      rd_en = 1'b0;
    end
    n_checks++; if (empty !== 1'b1) $display("FAIL fullrw_empty: got %b want 1", empty); else n_pass++;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_checks++; if (ovf !== 1'b0) $display("FAIL ovf_clr: got %b want 0", ovf); else n_pass++;
  endtask

  task automatic test_flush();
    push(8'h21); push(8'h22); push(8'h23);
    n_checks++; if (level !== 3'd3) $display("FAIL flush_pre_level: got %0d want 3", level); else n_pass++;
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    n_checks++; if (level !== 3'd0) $display("FAIL flush_level: got %0d want 0", level); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL flush_empty: got %b want 1", empty); else n_pass++;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++; if (udf !== ERR) $display("FAIL udf_set: got %b want %b", udf, ERR); else n_pass++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (udf !== ERR) $display("FAIL udf_flush_keep: got %b want %b", udf, ERR); else n_pass++;
    rd_en = 1'b1; clr_err = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++; if (udf !== ERR) $display("FAIL udf_evt_wins: got %b want %b", udf, ERR); else n_pass++;
    tick();
    clr_err = 1'b0;
    n_checks++; if (udf !== 1'b0) $display("FAIL udf_clr: got %b want 0", udf); else n_pass++;
    push(8'h42);
    n_checks++; if (rd_data !== 8'h42) $display("FAIL flush_head: got %h want 42", rd_data); else n_pass++;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    push(8'h31); push(8'h32); push(8'h33);
    n_checks++; if (level !== 3'd3) $display("FAIL rstmid_pre_level: got %0d want 3", level); else n_pass++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++; if (level !== 3'd0) $display("FAIL rstmid_level: got %0d want 0", level); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL rstmid_empty: got %b want 1", empty); else n_pass++;
    n_checks++; if (udf !== 1'b0 || ovf !== 1'b0) $display("FAIL rstmid_flags: got %b%b want 00", ovf, udf); else n_pass++;
  endtask

  task automatic test_depth1();
    n_checks++; if (d1_empty !== 1'b1) $display("FAIL d1_init_empty: got %b want 1", d1_empty); else n_pass++;
    d1_wr_en = 1'b1; d1_wr_data = 8'h3C;
    tick();
    d1_wr_en = 1'b0;
    n_checks++; if (d1_full !== 1'b1)  $display("FAIL d1_full: got %b want 1", d1_full); else n_pass++;
    n_checks++; if (d1_level !== 1'b1) $display("FAIL d1_level: got %0d want 1", d1_level); else n_pass++;
    d1_rd_en = 1'b1;
    #1;
    n_checks++; if (d1_rd_data !== 8'h3C) $display("FAIL d1_data: got %h want 3c", d1_rd_data); else n_pass++;
    tick();
    d1_rd_en = 1'b0;
    n_checks++; if (d1_empty !== 1'b1) $display("FAIL d1_empty: got %b want 1", d1_empty); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_tunnel();
    test_thresholds();
    test_flush();
    test_reset_mid();
    test_depth1();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
